// File: rtl/uart_tx_param_if.sv
// Word-stream handshake from the UART register block / FIFO into the transmitter.
// valid/ready: a word transfers on a rising clk edge where tx_valid && tx_ready are
// both high; tx_data must be stable while tx_valid is high, and the producer keeps
// tx_valid asserted until that edge. tx_ready never depends combinationally on tx_valid.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS payload LSB first, optional
// even/odd parity, 1 or 2 stop bits. Each bit lasts CLKS_PER_BIT clocks and the
// serial pin is driven straight from a flop.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  uart_tx_param_if.slave        tx_bus,
  output logic                  tx_line,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_INV   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_d;
  logic                 done_d;
  logic                 bit_end;

  assign bit_end          = (baud_q == BAUD_LAST);
  assign tx_bus.tx_ready  = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign state_dbg        = state_q;

  // State, counters, shift register and the registered pin/done outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_line <= 1'b1;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_line <= line_d;
      done    <= done_d;
    end
  end

  // Next-state, bit timing and the pin level for the next cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;
    line_d  = 1'b1;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (tx_bus.tx_valid) begin
          state_d = START;
          shift_d = tx_bus.tx_data;
          par_d   = (^tx_bus.tx_data) ^ PAR_INV;
          baud_d  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          // Index may reach DATA_BITS, which its width accommodates.
          idx_d   = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
            stop_d  = 1'b0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin level follows the state being entered so the flop holds it for the whole bit.
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
      PARITY:  line_d = par_d;
      default: line_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: short-bit-period instances in three parameter
// configurations plus one full 9600-baud instance checked by a receiver model.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int CPB   = 4;
  localparam int CPB_D = 5208;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;  // 50 MHz

  logic n_rst;
  logic n_rst_d;

  uart_tx_param_if #(.DATA_BITS(8)) if_a ();
  uart_tx_param_if #(.DATA_BITS(8)) if_b ();
  uart_tx_param_if #(.DATA_BITS(7)) if_c ();
  uart_tx_param_if #(.DATA_BITS(8)) if_d ();

  logic line_a, busy_a, done_a;
  logic line_b, busy_b, done_b;
  logic line_c, busy_c, done_c;
  logic line_d, busy_d, done_d;
  logic [2:0] st_a, st_b, st_c, st_d;

  uart_tx_param #(.CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .n_rst(n_rst), .tx_bus(if_a),
    .tx_line(line_a), .busy(busy_a), .done(done_a), .state_dbg(st_a));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_b (
    .clk(clk), .n_rst(n_rst), .tx_bus(if_b),
    .tx_line(line_b), .busy(busy_b), .done(done_b), .state_dbg(st_b));

  uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .n_rst(n_rst), .tx_bus(if_c),
    .tx_line(line_c), .busy(busy_c), .done(done_c), .state_dbg(st_c));

  uart_tx_param #(.CLKS_PER_BIT(CPB_D)) dut_d (
    .clk(clk), .n_rst(n_rst_d), .tx_bus(if_d),
    .tx_line(line_d), .busy(busy_d), .done(done_d), .state_dbg(st_d));

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [0:0] exp_q[$];
  logic rx_finished = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {line, busy, done, ready} of the selected instance
  function automatic logic [3:0] outs(input int d);
    case (d)
      0:       return {line_a, busy_a, done_a, if_a.tx_ready};
      1:       return {line_b, busy_b, done_b, if_b.tx_ready};
      2:       return {line_c, busy_c, done_c, if_c.tx_ready};
      default: return {line_d, busy_d, done_d, if_d.tx_ready};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input int d, input logic v, input logic [8:0] data);
    case (d)
      0:       begin if_a.tx_valid = v; if_a.tx_data = data[7:0]; end
      1:       begin if_b.tx_valid = v; if_b.tx_data = data[7:0]; end
      2:       begin if_c.tx_valid = v; if_c.tx_data = data[6:0]; end
      default: begin if_d.tx_valid = v; if_d.tx_data = data[7:0]; end
    endcase
  endtask

  // Entered at the negedge of the first start-bit cycle; leaves in the done cycle.
  task automatic check_frame(input int d, input logic [15:0] bits, input int nslots);
    logic [3:0] o;
    logic [0:0] e;
    int cyc;
    for (int s = 0; s < nslots; s++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(bits[s]);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = outs(d);
      check($sformatf("line[d%0d c%0d]", d, cyc), {31'd0, o[3]}, {31'd0, e});
      check($sformatf("busy[d%0d c%0d]", d, cyc), {31'd0, o[2]}, 32'd1);
      check($sformatf("done_early[d%0d c%0d]", d, cyc), {31'd0, o[1]}, 32'd0);
      check($sformatf("ready_busy[d%0d c%0d]", d, cyc), {31'd0, o[0]}, 32'd0);
      cyc++;
      @(negedge clk);
    end
    o = outs(d);
    check($sformatf("done_pulse[d%0d]", d), {31'd0, o[1]}, 32'd1);
    check($sformatf("busy_end[d%0d]", d), {31'd0, o[2]}, 32'd0);
    check($sformatf("ready_end[d%0d]", d), {31'd0, o[0]}, 32'd1);
    check($sformatf("line_end[d%0d]", d), {31'd0, o[3]}, 32'd1);
  endtask

  task automatic send(input int d, input logic [8:0] data, input logic [15:0] bits, input int nslots);
    logic [3:0] o;
    @(negedge clk);
    drive(d, 1'b1, data);
    o = outs(d);
    check($sformatf("ready_idle[d%0d]", d), {31'd0, o[0]}, 32'd1);
    @(negedge clk);
    drive(d, 1'b0, ~data);  // later data changes must not reach the frame
    check_frame(d, bits, nslots);
    @(negedge clk);
    o = outs(d);
    check($sformatf("done_one_cycle[d%0d]", d), {31'd0, o[1]}, 32'd0);
  endtask

  // Reference receiver on the full-rate instance: sample at mid-bit.
  task automatic rx_model();
    int low;
    logic [7:0] rx;
    logic par, stp;
    int wait_cnt;
    @(negedge clk);
    drive(3, 1'b1, 9'h041);
    @(negedge clk);
    drive(3, 1'b0, 9'h000);
    low = 0;
    while (line_d == 1'b0 && low < 2 * CPB_D) begin
      low++;
      @(negedge clk);
    end
    check("d_bit_ns", low * 20, 32'd104160);
    rx = '0;
    repeat (CPB_D / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx[i] = line_d;
      repeat (CPB_D) @(negedge clk);
    end
    par = line_d;
    repeat (CPB_D) @(negedge clk);
    stp = line_d;
    check("d_rx_char", {24'd0, rx}, 32'h41);  // 'A'
    check("d_rx_parity", {31'd0, par}, 32'd0);
    check("d_rx_stop", {31'd0, stp}, 32'd1);
    wait_cnt = 0;
    while (done_d == 1'b0 && wait_cnt < 2 * CPB_D) begin
      wait_cnt++;
      @(negedge clk);
    end
    check("d_done_seen", {31'd0, done_d}, 32'd1);
    rx_finished = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         dut;
    logic [8:0] data;
    logic [15:0] bits;   // line level per bit slot, slot 0 = start, in LSB
    int         nslots;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0] o;
    logic saw_done;
    logic saw_low;
    int wait_cnt;

    // {stop(s), parity, data msb..lsb, start}
    vecs[0] = '{0, 9'h0A5, {5'd0, 11'b1_0_10100101_0}, 11};  // 4 ones -> even 0
    vecs[1] = '{0, 9'h000, {5'd0, 11'b1_0_00000000_0}, 11};
    vecs[2] = '{0, 9'h001, {5'd0, 11'b1_1_00000001_0}, 11};
    vecs[3] = '{0, 9'h0FF, {5'd0, 11'b1_0_11111111_0}, 11};
    vecs[4] = '{1, 9'h007, {5'd0, 11'b1_0_00000111_0}, 11};  // odd: 3 ones -> 0
    vecs[5] = '{1, 9'h003, {5'd0, 11'b1_1_00000011_0}, 11};  // odd: 2 ones -> 1
    vecs[6] = '{2, 9'h055, {6'd0, 10'b11_1010101_0}, 10};    // 7 bits, 2 stops
    vecs[7] = '{2, 9'h00F, {6'd0, 10'b11_0001111_0}, 10};

    n_rst   = 1'b0;
    n_rst_d = 1'b0;
    for (int d = 0; d < 4; d++) drive(d, 1'b0, 9'h000);

    @(negedge clk);
    check("rst_line", {31'd0, line_a}, 32'd1);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_state", {29'd0, st_a}, 32'd0);
    n_rst   = 1'b1;
    n_rst_d = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      o = outs(d);
      check($sformatf("ready_after_rst[d%0d]", d), {31'd0, o[0]}, 32'd1);
    end

    fork
      rx_model();
    join_none

    for (int i = 0; i < 8; i++) send(vecs[i].dut, vecs[i].data, vecs[i].bits, vecs[i].nslots);

    // Back-to-back with tx_valid held high; 0xFF shown mid-frame must be ignored.
    @(negedge clk);
    drive(0, 1'b1, 9'h011);
    @(negedge clk);
    drive(0, 1'b1, 9'h0FF);
    fork
      begin
        repeat (20) @(negedge clk);
        drive(0, 1'b1, 9'h022);
      end
    join_none
    check_frame(0, {5'd0, 11'b1_0_00010001_0}, 11);
    @(negedge clk);
    drive(0, 1'b0, 9'h000);
    check_frame(0, {5'd0, 11'b1_0_00100010_0}, 11);

    // Reset during data bit 3 of 0xF7 (bit 3 is 0, so the pin is low there).
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b1, 9'h0F7);
    @(negedge clk);
    drive(0, 1'b0, 9'h000);
    repeat (4 * CPB + 1) @(negedge clk);
    check("pre_rst_line", {31'd0, line_a}, 32'd0);
    n_rst = 1'b0;
    #1;
    check("mid_rst_line", {31'd0, line_a}, 32'd1);
    check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    check("mid_rst_done", {31'd0, done_a}, 32'd0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, if_a.tx_ready}, 32'd1);
    check("post_rst_busy", {31'd0, busy_a}, 32'd0);
    check("post_rst_line", {31'd0, line_a}, 32'd1);
    saw_done = 1'b0;
    saw_low  = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
      if (!line_a) saw_low = 1'b1;
    end
    check("no_done_after_abort", {31'd0, saw_done}, 32'd0);
    check("line_idle_after_abort", {31'd0, saw_low}, 32'd0);
    send(0, 9'h03C, {5'd0, 11'b1_0_00111100_0}, 11);

    wait_cnt = 0;
    while (!rx_finished && wait_cnt < 70000) begin
      wait_cnt++;
      @(negedge clk);
    end
    check("rx_model_finished", {31'd0, rx_finished}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
